// File: rtl/sim_stop_controller_pkg.sv
// Shared types and defaults for the simulation stop controller.
package sim_stop_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  localparam int DEF_NUM_CH  = 2;
  localparam int DEF_CNT_W   = 16;
  localparam int DEF_TIMEOUT = 1000;
  localparam int DEF_DRAIN   = 4;

  // A run passes only when every channel finished, nothing failed and it did not time out.
  function automatic logic calc_pass(input logic all_done, input logic any_fail,
                                     input logic timed_out);
    return all_done & ~any_fail & ~timed_out;
  endfunction

endpackage

// File: rtl/sim_stop_controller_if.sv
// Monitor/verdict bundle between the test harness and the stop controller.
interface sim_stop_controller_if
  import sim_stop_controller_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CNT_W  = DEF_CNT_W
);
  // No valid/ready pairs: start, ch_done and ch_fail are sampled on every rising
  // clock edge as levels (a one-cycle pulse counts); all outputs are registered.
  logic              start;
  logic [NUM_CH-1:0] ch_done;
  logic [NUM_CH-1:0] ch_fail;
  logic              busy;
  logic              stop;
  logic              pass;
  logic              fail;
  logic              timed_out;
  logic [NUM_CH-1:0] done_mask;
  logic [NUM_CH-1:0] fail_mask;
  logic [CNT_W-1:0]  cycle_count;

  modport master (
    output start, ch_done, ch_fail,
    input  busy, stop, pass, fail, timed_out, done_mask, fail_mask, cycle_count
  );

  modport slave (
    input  start, ch_done, ch_fail,
    output busy, stop, pass, fail, timed_out, done_mask, fail_mask, cycle_count
  );
endinterface

// File: rtl/sim_stop_controller_flags.sv
// sticky_flag_bank: N set-only flags with a common enable and async clear.
module sticky_flag_bank #(
  parameter int N = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en_i,
  input  logic [N-1:0] set_i,
  output logic [N-1:0] flags_o,
  output logic [N-1:0] flags_next_o
);
  logic [N-1:0] flags_q;
  logic [N-1:0] flags_d;

  always_comb begin
    flags_d = flags_q;
    if (en_i) flags_d = flags_q | set_i;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) flags_q <= '0;
    else       flags_q <= flags_d;
  end

  assign flags_o      = flags_q;
  // Next value lets the owner judge completion on the same edge the input arrives.
  assign flags_next_o = flags_d;
endmodule

// File: rtl/sim_stop_controller.sv
// Watches per-channel done/fail flags, enforces a RUN-cycle limit and issues a stop request with a verdict.
module sim_stop_controller
  import sim_stop_controller_pkg::*;
#(
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int DRAIN   = DEF_DRAIN
) (
  input  logic                  clock,
  input  logic                  reset,
  sim_stop_controller_if.slave  bus,
  output state_t                state_o
);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [7:0]       DRAIN_LAST   = 8'((DRAIN > 0) ? DRAIN - 1 : 0);

  state_t            state_q, state_d;
  logic [7:0]        drain_cnt_q, drain_cnt_d;
  logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;
  logic              busy_q, busy_d;
  logic              stop_q, stop_d;
  logic              pass_q, pass_d;
  logic              fail_q, fail_d;
  logic              timed_out_q, timed_out_d;

  logic              mask_en;
  logic [NUM_CH-1:0] done_mask, done_next;
  logic [NUM_CH-1:0] fail_mask, fail_next;
  logic              all_done, any_fail, timeout_hit;

  assign mask_en = (state_q == ST_RUN) || (state_q == ST_DRAIN);

  sticky_flag_bank #(.N(NUM_CH)) u_done_bank (
    .clock        (clock),
    .reset        (reset),
    .en_i         (mask_en),
    .set_i        (bus.ch_done),
    .flags_o      (done_mask),
    .flags_next_o (done_next)
  );

  sticky_flag_bank #(.N(NUM_CH)) u_fail_bank (
    .clock        (clock),
    .reset        (reset),
    .en_i         (mask_en),
    .set_i        (bus.ch_fail),
    .flags_o      (fail_mask),
    .flags_next_o (fail_next)
  );

  assign all_done    = &done_next;
  assign any_fail    = |fail_next;
  assign timeout_hit = (TIMEOUT != 0) && (cycle_count_q == TIMEOUT_LAST);

  always_comb begin
    state_d       = state_q;
    drain_cnt_d   = drain_cnt_q;
    cycle_count_d = cycle_count_q;
    busy_d        = busy_q;
    stop_d        = stop_q;
    pass_d        = pass_q;
    fail_d        = fail_q;
    timed_out_d   = timed_out_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          busy_d  = 1'b1;
        end
      end
      ST_RUN: begin
        if (cycle_count_q != '1) cycle_count_d = cycle_count_q + 1'b1;
        if (all_done || any_fail || timeout_hit) begin
          // Timeout only counts when it is the sole reason for leaving RUN.
          timed_out_d = timeout_hit & ~all_done & ~any_fail;
          if (DRAIN == 0) begin
            state_d = ST_STOP;
            busy_d  = 1'b0;
            stop_d  = 1'b1;
            fail_d  = any_fail;
            pass_d  = calc_pass(all_done, any_fail, timed_out_d);
          end else begin
            state_d     = ST_DRAIN;
            drain_cnt_d = '0;
          end
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d = ST_STOP;
          busy_d  = 1'b0;
          stop_d  = 1'b1;
          fail_d  = any_fail;
          pass_d  = calc_pass(all_done, any_fail, timed_out_q);
        end else begin
          drain_cnt_d = drain_cnt_q + 8'd1;
        end
      end
      ST_STOP: begin
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      drain_cnt_q   <= '0;
      cycle_count_q <= '0;
      busy_q        <= 1'b0;
      stop_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_q        <= 1'b0;
      timed_out_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      drain_cnt_q   <= drain_cnt_d;
      cycle_count_q <= cycle_count_d;
      busy_q        <= busy_d;
      stop_q        <= stop_d;
      pass_q        <= pass_d;
      fail_q        <= fail_d;
      timed_out_q   <= timed_out_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.stop        = stop_q;
  assign bus.pass        = pass_q;
  assign bus.fail        = fail_q;
  assign bus.timed_out   = timed_out_q;
  assign bus.done_mask   = done_mask;
  assign bus.fail_mask   = fail_mask;
  assign bus.cycle_count = cycle_count_q;
  assign state_o         = state_q;
endmodule
